// File: rtl/dec_pipe_pkg.sv
// Shared types for the registered select decoder: decode modes and the upper
// bound on the number of decoded lines.
package dec_pipe_pkg;

    typedef enum logic [1:0] {
        MODE_ONEHOT  = 2'd0,
        MODE_THERM   = 2'd1,
        MODE_ONECOLD = 2'd2,
        MODE_BCAST   = 2'd3
    } dec_mode_t;

    localparam int DEC_MAX_OUT = 64;

endpackage

// File: rtl/dec_pipe_core.sv
// Purpose: combinational select decoder (onehot/therm/onecold/bcast) with range check.
// Latency: 0 cycles, purely combinational.
// Backpressure: none; the caller owns the handshake.
module dec_pipe_core
    import dec_pipe_pkg::*;
#(
    parameter  int NUM_OUT = 3,
    localparam int SEL_W   = $clog2(NUM_OUT)
) (
    input  logic [SEL_W-1:0]   sel,
    input  logic               dis,
    input  dec_mode_t          mode,
    output logic [NUM_OUT-1:0] dec,
    output logic               err
);

    always_comb begin
        dec = '0;
        err = 1'b0;
        if (dis) begin
            dec = '0;
        end else if (int'(sel) >= NUM_OUT) begin
            // Only reachable when NUM_OUT is not a power of two.
            err = 1'b1;
        end else begin
            for (int i = 0; i < NUM_OUT; i++) begin
                case (mode)
                    MODE_ONEHOT:  dec[i] = (i == int'(sel));
                    MODE_THERM:   dec[i] = (i <= int'(sel));
                    MODE_ONECOLD: dec[i] = (i != int'(sel));
                    default:      dec[i] = 1'b1;
                endcase
            end
        end
    end

endmodule

// File: rtl/dec_pipe.sv
// Purpose: registered select decoder with valid/ready handshake; DEC_PIPE_HIT_CNT_EN adds per-line hit counters.
// Latency: 1 cycle from accept to out_valid; 1 beat/cycle with out_ready high.
// Backpressure: in_ready = !out_valid || out_ready; output held stable while stalled.
module dec_pipe
    import dec_pipe_pkg::*;
#(
    parameter  int NUM_OUT = 3,
    parameter  int CNT_W   = 8,
    localparam int SEL_W   = $clog2(NUM_OUT)
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [SEL_W-1:0]         in_sel,
    input  logic                     in_dis,
    input  dec_mode_t                in_mode,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [NUM_OUT-1:0]       out_dec,
    output logic                     out_err
`ifdef DEC_PIPE_HIT_CNT_EN
    ,
    output logic [NUM_OUT*CNT_W-1:0] hit_cnt
`endif
);

    if (NUM_OUT < 2 || NUM_OUT > DEC_MAX_OUT || CNT_W < 1) begin : g_bad_param
        $error("dec_pipe: NUM_OUT must be 2..DEC_MAX_OUT and CNT_W >= 1");
    end

    logic [NUM_OUT-1:0] core_dec;
    logic               core_err;
    logic               accept;
    logic               pop;

    dec_pipe_core #(.NUM_OUT(NUM_OUT)) u_core (
        .sel  (in_sel),
        .dis  (in_dis),
        .mode (in_mode),
        .dec  (core_dec),
        .err  (core_err)
    );

    assign in_ready = !out_valid || out_ready;
    assign accept   = in_valid && in_ready;
    assign pop      = out_valid && out_ready;

    // On pop without push only out_valid drops; out_dec/out_err keep their value.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid <= 1'b0;
            out_dec   <= '0;
            out_err   <= 1'b0;
        end else if (accept) begin
            out_valid <= 1'b1;
            out_dec   <= core_dec;
            out_err   <= core_err;
        end else if (pop) begin
            out_valid <= 1'b0;
        end
    end

`ifdef DEC_PIPE_HIT_CNT_EN
    for (genvar i = 0; i < NUM_OUT; i++) begin : g_hit
        logic [CNT_W-1:0] cnt;

        // Saturating; error beats carry an all-zero vector but are excluded explicitly.
        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                cnt <= '0;
            end else if (pop && !out_err && out_dec[i] && (cnt != '1)) begin
                cnt <= cnt + 1'b1;
            end
        end

        assign hit_cnt[i*CNT_W +: CNT_W] = cnt;
    end
`endif

endmodule

// File: tb/tb_dec_pipe.sv
// Randomised and directed bench for dec_pipe against a queue-based reference model.
module tb_dec_pipe;
    import dec_pipe_pkg::*;

    localparam int NUM_OUT = 3;
    localparam int CNT_W   = 2;
    localparam int SEL_W   = $clog2(NUM_OUT);
    localparam int CNT_MAX = (1 << CNT_W) - 1;

    logic               clk = 1'b0;
    logic               rst;
    logic               in_valid;
    logic               in_ready;
    logic [SEL_W-1:0]   in_sel;
    logic               in_dis;
    dec_mode_t          in_mode;
    logic               out_valid;
    logic               out_ready;
    logic [NUM_OUT-1:0] out_dec;
    logic               out_err;
`ifdef DEC_PIPE_HIT_CNT_EN
    logic [NUM_OUT*CNT_W-1:0] hit_cnt;
`endif

    int checks = 0;
    int errors = 0;

    typedef struct packed {
        logic               err;
        logic [NUM_OUT-1:0] dec;
    } beat_t;

    beat_t       exp_q[$];
    int unsigned exp_cnt[NUM_OUT];

    always #5 clk = ~clk;

    dec_pipe #(.NUM_OUT(NUM_OUT), .CNT_W(CNT_W)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_sel    (in_sel),
        .in_dis    (in_dis),
        .in_mode   (in_mode),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_dec   (out_dec),
        .out_err   (out_err)
`ifdef DEC_PIPE_HIT_CNT_EN
        ,
        .hit_cnt   (hit_cnt)
`endif
    );

    // Reference decode from plain arithmetic on the mode rules.
    function automatic beat_t model(int sel, bit dis, int mode);
        beat_t b;
        int    all;
        int    v;
        all   = (1 << NUM_OUT) - 1;
        v     = 0;
        b.err = 1'b0;
        if (!dis) begin
            if (sel >= NUM_OUT) begin
                b.err = 1'b1;
            end else begin
                case (mode)
                    0:       v = 1 << sel;
                    1:       v = (1 << (sel + 1)) - 1;
                    2:       v = all & ~(1 << sel);
                    default: v = all;
                endcase
            end
        end
        b.dec = v[NUM_OUT-1:0];
        return b;
    endfunction

    task automatic clear_model();
        exp_q.delete();
        for (int i = 0; i < NUM_OUT; i++) exp_cnt[i] = 0;
    endtask

    // One clock: drive inputs (called at posedge+1), check at negedge, advance model at posedge.
    task automatic cycle(bit v, int sel, bit dis, int mode, bit ordy);
        beat_t b;
        bit    exp_rdy;
        bit    exp_vld;
        in_valid  = v;
        in_sel    = SEL_W'(sel);
        in_dis    = dis;
        in_mode   = dec_mode_t'(2'(mode));
        out_ready = ordy;
        @(negedge clk);
        exp_vld = (exp_q.size() != 0);
        exp_rdy = !exp_vld || ordy;
        checks++;
        if (in_ready !== exp_rdy) begin
            errors++;
            $display("FAIL in_ready got %b want %b at %0t", in_ready, exp_rdy, $time);
        end
        checks++;
        if (out_valid !== exp_vld) begin
            errors++;
            $display("FAIL out_valid got %b want %b at %0t", out_valid, exp_vld, $time);
        end
        if (exp_vld) begin
            checks++;
            if ({out_err, out_dec} !== exp_q[0]) begin
                errors++;
                $display("FAIL out_beat got err=%b dec=%b want err=%b dec=%b at %0t",
                         out_err, out_dec, exp_q[0].err, exp_q[0].dec, $time);
            end
        end
`ifdef DEC_PIPE_HIT_CNT_EN
        for (int i = 0; i < NUM_OUT; i++) begin
            checks++;
            if (hit_cnt[i*CNT_W +: CNT_W] !== CNT_W'(exp_cnt[i])) begin
                errors++;
                $display("FAIL hit_cnt[%0d] got %0d want %0d at %0t",
                         i, hit_cnt[i*CNT_W +: CNT_W], exp_cnt[i], $time);
            end
        end
`endif
        @(posedge clk);
        if (exp_vld && ordy) begin
            b = exp_q.pop_front();
            if (!b.err) begin
                for (int i = 0; i < NUM_OUT; i++)
                    if (b.dec[i] && exp_cnt[i] < CNT_MAX) exp_cnt[i]++;
            end
        end
        if (v && exp_rdy) exp_q.push_back(model(sel, dis, mode));
        #1;
    endtask

    task automatic test_reset();
        rst       = 1'b0;
        in_valid  = 1'b0;
        in_sel    = '0;
        in_dis    = 1'b0;
        in_mode   = MODE_ONEHOT;
        out_ready = 1'b0;
        #2 rst = 1'b1;
        #1;
        checks++;
        if (out_valid !== 1'b0 || out_dec !== '0 || out_err !== 1'b0) begin
            errors++;
            $display("FAIL reset_state got vld=%b dec=%b err=%b want 0/0/0",
                     out_valid, out_dec, out_err);
        end
        checks++;
        if (in_ready !== 1'b1) begin
            errors++;
            $display("FAIL reset_in_ready got %b want 1", in_ready);
        end
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        clear_model();
        @(posedge clk);
        #1;
        cycle(0, 0, 0, 0, 1);
    endtask

    task automatic test_onehot_seq();
        for (int s = 0; s < NUM_OUT; s++) cycle(1, s, 0, 0, 1);
        cycle(0, 0, 0, 0, 1);
    endtask

    task automatic test_modes();
        int    tbl_mode[6] = '{1, 2, 3, 3, 1, 1};
        int    tbl_sel [6] = '{1, 1, 2, 0, 0, 2};
        bit    tbl_dis [6] = '{0, 0, 0, 1, 0, 0};
        logic [NUM_OUT-1:0] tbl_exp[6] = '{3'b011, 3'b101, 3'b111, 3'b000, 3'b001, 3'b111};
        for (int t = 0; t < 6; t++) begin
            cycle(1, tbl_sel[t], tbl_dis[t], tbl_mode[t], 1);
            checks++;
            if (out_dec !== tbl_exp[t] || out_err !== 1'b0) begin
                errors++;
                $display("FAIL mode_case%0d got dec=%b err=%b want dec=%b err=0",
                         t, out_dec, out_err, tbl_exp[t]);
            end
        end
        cycle(0, 0, 0, 0, 1);
    endtask

    task automatic test_range();
        cycle(1, 3, 0, 3, 1);
        checks++;
        if (out_dec !== 3'b000 || out_err !== 1'b1) begin
            errors++;
            $display("FAIL range_err got dec=%b err=%b want dec=000 err=1", out_dec, out_err);
        end
        cycle(1, 0, 0, 0, 1);
        checks++;
        if (out_dec !== 3'b001 || out_err !== 1'b0) begin
            errors++;
            $display("FAIL range_clear got dec=%b err=%b want dec=001 err=0", out_dec, out_err);
        end
        cycle(0, 0, 0, 0, 1);
    endtask

    task automatic test_backpressure();
        cycle(1, 0, 0, 0, 1);
        repeat (4) cycle(1, 1, 0, 1, 0);
        cycle(1, 1, 0, 1, 1);
        cycle(0, 0, 0, 0, 1);
        cycle(0, 0, 0, 0, 1);
    endtask

    task automatic test_random();
        for (int n = 0; n < 400; n++) begin
            cycle(($urandom_range(0, 3) != 0), int'($urandom_range(0, 3)),
                  ($urandom_range(0, 7) == 0), int'($urandom_range(0, 3)),
                  ($urandom_range(0, 2) != 0));
        end
        repeat (2) cycle(0, 0, 0, 0, 1);
    endtask

    task automatic test_reset_midstall();
        cycle(1, 1, 0, 0, 0);
        cycle(1, 2, 0, 0, 0);
        rst = 1'b1;
        #1;
        checks++;
        if (out_valid !== 1'b0 || out_dec !== '0 || out_err !== 1'b0) begin
            errors++;
            $display("FAIL midstall_reset got vld=%b dec=%b err=%b want 0/0/0",
                     out_valid, out_dec, out_err);
        end
`ifdef DEC_PIPE_HIT_CNT_EN
        checks++;
        if (hit_cnt !== '0) begin
            errors++;
            $display("FAIL midstall_hit_cnt got %h want 0", hit_cnt);
        end
`endif
        in_valid = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        clear_model();
        @(posedge clk);
        #1;
        checks++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
            errors++;
            $display("FAIL post_reset got in_ready=%b out_valid=%b want 1/0", in_ready, out_valid);
        end
        cycle(0, 0, 0, 0, 0);
    endtask

`ifdef DEC_PIPE_HIT_CNT_EN
    task automatic test_hit_cnt();
        repeat (5) cycle(1, 0, 0, 0, 1);
        cycle(0, 0, 0, 0, 1);
        checks++;
        if (hit_cnt[0 +: CNT_W] !== 2'd3 || hit_cnt[CNT_W +: CNT_W] !== 2'd0 ||
            hit_cnt[2*CNT_W +: CNT_W] !== 2'd0) begin
            errors++;
            $display("FAIL hit_sat got %h want line0=3 others=0", hit_cnt);
        end
        cycle(1, 3, 0, 3, 1);
        cycle(0, 0, 0, 0, 1);
        checks++;
        if (hit_cnt[CNT_W +: CNT_W] !== 2'd0 || hit_cnt[2*CNT_W +: CNT_W] !== 2'd0) begin
            errors++;
            $display("FAIL hit_err_beat got %h want lines1-2=0", hit_cnt);
        end
    endtask
`endif

    initial begin
        test_reset();
        test_onehot_seq();
        test_modes();
        test_range();
        test_backpressure();
        test_random();
        test_reset_midstall();
`ifdef DEC_PIPE_HIT_CNT_EN
        test_hit_cnt();
`endif
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/dec_pipe.md
Name: dec_pipe

Overview:
- Parametrised, registered successor to the team's small 2-bit decoder. Decodes a select code into an NUM_OUT-bit output vector, with a disable input and four output modes.
- Adds range checking, an elastic valid/ready handshake and a 1-cycle output register.
- Sits between a control/sequencer block and enable/select fan-out logic; also a coverage-training target with deliberate corner cases.

Parameters:
- NUM_OUT, 3, number of decoded output lines (2..64); need not be a power of two.
- SEL_W, $clog2(NUM_OUT) (local, derived), width of the select code.
- CNT_W, 8, width of each per-line hit counter (optional feature only).

Ports:
- clk  in  1  clock; all logic on rising edge.
- rst  in  1  asynchronous, active-high reset.
- in_valid  in  1  request present.
- in_ready  out  1  block can accept request this cycle.
- in_sel  in  SEL_W  select code.
- in_dis  in  1  disable; forces all-zero decode.
- in_mode  in  2  decode mode (dec_mode_t).
- out_valid  out  1  decoded result held in output register.
- out_ready  in  1  consumer accepts result.
- out_dec  out  NUM_OUT  decoded vector.
- out_err  out  1  result came from an out-of-range select.
- hit_cnt  out  NUM_OUT*CNT_W  per-line hit counters; present only with DEC_PIPE_HIT_CNT_EN.

Behaviour:
- Reset: out_valid=0, out_dec=0, out_err=0, hit counters=0, all asynchronously on rst rising. in_ready=1 while in reset and after release. A beat in flight when rst asserts is dropped, not replayed.
- in_ready = !out_valid || out_ready (combinational; no path from in_valid to in_ready).
- Accept: in_valid && in_ready. On the next edge the output register loads the decode, and out_valid=1.
- Latency: exactly 1 cycle from accept to out_valid.
- Throughput: 1 beat/cycle when out_ready is held high.
- Simultaneous pop+push: out_valid stays 1 and the register takes the new beat.
- Pop without push: out_valid returns to 0; out_dec and out_err keep their last values (don't-care).
- Stall: while out_valid && !out_ready, out_dec and out_err are stable and no input is taken.
- Decode priority, highest first:
  1. in_dis=1 -> out_dec=0, out_err=0, regardless of sel/mode.
  2. in_sel >= NUM_OUT -> out_dec=0, out_err=1. Only reachable when NUM_OUT is not a power of two.
  3. Mode decode (k = in_sel, bit index 0 = LSB):
     - MODE_ONEHOT (0): only bit k set.
     - MODE_THERM (1): bits 0..k set.
     - MODE_ONECOLD (2): all bits set except bit k.
     - MODE_BCAST (3): all bits set; in_sel ignored, but the range check still applies.
- Boundary cases:
  - k=0 in MODE_THERM gives only bit 0.
  - k=NUM_OUT-1 in MODE_THERM gives all ones.
  - NUM_OUT=2 gives SEL_W=1, with no error path.

Optional Feature:
- Macro: DEC_PIPE_HIT_CNT_EN.
- Defined:
  - Each output line i has a CNT_W-bit saturating counter.
  - The counter increments on the edge where a beat is popped (out_valid && out_ready) with out_dec[i]=1.
  - It holds at 2^CNT_W-1.
  - Beats with out_err=1 count nothing.
  - Counters are exported on hit_cnt; line i occupies bits [i*CNT_W +: CNT_W].
- Undefined: no counters and no hit_cnt port; all other behaviour is identical.

Decomposition:
- Package dec_pipe_pkg holds:
  - typedef enum logic [1:0] dec_mode_t {MODE_ONEHOT, MODE_THERM, MODE_ONECOLD, MODE_BCAST};
  - DEC_MAX_OUT = 64.
- Sub-module dec_pipe_core: purely combinational; (sel, dis, mode) -> (dec, err), parametrised on NUM_OUT.
- Top dec_pipe: handshake, output register and optional counters.

Test Plan:
- Reset mid-stall: push sel=1, hold out_ready=0, assert rst -> out_valid=0, out_dec=0 immediately (async); in_ready=1 after release.
- NUM_OUT=3, out_ready=1, push sel=0,1,2 in MODE_ONEHOT on consecutive cycles -> out_dec 3'b001, 3'b010, 3'b100 one cycle after each, out_valid continuously 1.
- MODE_THERM sel=1 -> 3'b011. MODE_ONECOLD sel=1 -> 3'b101. MODE_BCAST sel=2 -> 3'b111. in_dis=1 with MODE_BCAST -> 3'b000, out_err=0.
- NUM_OUT=3, sel=3 -> out_dec=3'b000, out_err=1. The next beat sel=0 clears out_err.
- Backpressure: out_ready=0 for 4 cycles with in_valid=1 -> in_ready=0; out_dec stable; the first beat is delivered once out_ready=1 and the second follows on the next cycle; no loss or duplication.
- With DEC_PIPE_HIT_CNT_EN, CNT_W=2: pop sel=0 onehot 5 times -> hit_cnt line0=3 (saturated), lines 1-2=0. An out-of-range beat increments nothing.
